gtrg_scope_fifo: RTL and testbench
==================================

# gtrg_scope_fifo

Parametrised trigger-record FIFO for the DMB control path, the successor to the fixed 5-CFEB/1024-deep GTRG FIFO. On each delayed global push it stores one record per L1A: a BX stamp plus a per-channel DAV scope window of configurable width, with optional channel masking. It provides full-depth occupancy, an almost-full warning, sticky overflow/underflow flags and a dropped-push counter. It sits between the push-delay/DAV-delay logic and the readout sequencer.

## Interface
Parameters:
- NCH, 5: number of DAV channels.
- SCOPE, 5: scope window bits per channel; minimum 2.
- DEPTH_LOG2, 10: FIFO depth is 2^DEPTH_LOG2 records.
- BXW, 12: BX counter and stamp width.
- AF_THR, 1016: almost-full threshold, compared as COUNT >= AF_THR.

Ports:
- CLK  in  1  system clock.
- RDRST  in  1  reset. Asynchronous, active-high; clock CLK.
- PUSH  in  1  delayed trigger push, one-cycle pulse.
- POP  in  1  readout pop request.
- BC0  in  1  synchronous BX counter reset.
- BXMAX  in  BXW  last BX value before wrap (3563 in the standard configuration).
- DAV  in  NCH  delayed DAV per channel.
- KILL  in  NCH  per-channel mask; 1 forces that channel's DAV to 0.
- CLRERR  in  1  synchronous clear of OVFL, UNFL and DROPCNT.
- DOUT_VALID  out  1  one-cycle strobe qualifying the DOUT_* outputs.
- DOUT_DAV  out  NCH*SCOPE  scope windows; channel c occupies bits [c*SCOPE +: SCOPE].
- DOUT_BX  out  BXW  BX stamp.
- EMPTY_B  out  1  FIFO not empty.
- FULL  out  1  COUNT == 2^DEPTH_LOG2.
- AFULL  out  1  COUNT >= AF_THR.
- COUNT  out  DEPTH_LOG2+1  occupancy.
- OVFL  out  1  sticky flag: a push was dropped.
- UNFL  out  1  sticky flag: a pop was issued while empty.
- DROPCNT  out  8  saturating count of dropped pushes.

## Operation
- Masked DAV: dm = DAV & ~KILL.
- Per-channel scope shift register, updated every cycle: sh[c] <= {sh[c][SCOPE-3:0], dm[c]}.
- Window captured on a push: win[c] = {sh[c], dm[c]}. Bit 0 is the push cycle; bit SCOPE-1 is the oldest sample.
- BX counter bx, updated every cycle, with priority in this order:
  - BC0 -> bx becomes 0;
  - bx == BXMAX -> bx becomes 0;
  - otherwise bx becomes bx+1.
- Accepts:
  - rd_ok = POP & (COUNT != 0).
  - wr_ok = PUSH & (COUNT < DEPTH | rd_ok).
- Write: when wr_ok, the record {bx, win} is stored at wptr, where bx is the current (pre-update) counter value. wptr then increments, wrapping modulo the depth.
- Read: when rd_ok, the record at rptr is registered onto DOUT_*, DOUT_VALID is 1 the next cycle, and rptr increments modulo the depth. DOUT_* hold their value between pops.
- COUNT:
  - +1 on wr_ok & ~rd_ok;
  - -1 on rd_ok & ~wr_ok;
  - unchanged when both or neither occur.
  - All 2^DEPTH_LOG2 entries are usable.
- Push while full with no pop: the record is dropped, OVFL is set and DROPCNT increments, saturating at 255.
- Pop while empty: ignored, DOUT_* unchanged, DOUT_VALID stays 0, UNFL is set.
- CLRERR clears OVFL, UNFL and DROPCNT. An error event in the same cycle as CLRERR wins.
- Reset values:
  - pointers, COUNT, bx, all sh, OVFL, UNFL, DROPCNT, DOUT_* and DOUT_VALID are 0;
  - EMPTY_B = 0, FULL = 0, AFULL = 0;
  - RAM contents are not cleared.
- Reset mid-operation discards all stored records. The first record after reset is read back from address 0.

## Timing
- POP to DOUT_VALID/DOUT_*: 1 cycle.
- Flag timing:
  - EMPTY_B, FULL, AFULL and COUNT are decoded from registered state.
  - They update the cycle after the push or pop that changes them.
- A push and pop in the same cycle on a FIFO holding one record returns the old record. The new record stays, and COUNT stays 1.
- Write-to-read turnaround: a record written in cycle n can be popped in cycle n+1. Its data appears in cycle n+2.
- The window seen at a push at cycle n is dm[c] sampled at cycles n-SCOPE+1 .. n.

## Structure
- Shared package gtrg_pkg:
  - default NCH/SCOPE/DEPTH_LOG2/BXW;
  - BX_MAX_LHC = 3563;
  - the record-width function BXW + NCH*SCOPE.
- One sub-module, gtrg_sdp_ram: simple dual-port, registered-read RAM with (* ram_style = "block" *).
- Pointers, COUNT, flags, the BX counter and the scope registers live in the top level.

## Test plan
- Reset, then DAV[2] high for one cycle, PUSH 2 cycles later, then POP -> DOUT_VALID 1 cycle after POP; channel 2 window = 5'b00100, other channels 0.
- KILL = 5'b00100 with the same stimulus -> all windows 0. BC0 then 10 cycles to the push -> DOUT_BX = 10.
- BXMAX = 3563 with no BC0 -> stamp sequence 3562, 3563, 0.
- Push 1024 times -> FULL = 1 and COUNT = 1024; AFULL rises after the 1016th push. A further 3 pushes -> OVFL = 1 and DROPCNT = 3. Popping 1024 times returns stamps in order. A pop while empty -> UNFL = 1. CLRERR -> OVFL, UNFL and DROPCNT are 0.
- Full FIFO with PUSH and POP in the same cycle -> no drop, COUNT stays 1024, oldest record is read.
- RDRST asserted mid-stream with 5 records held -> COUNT = 0, EMPTY_B = 0, DOUT_VALID = 0 immediately. The next push-pop returns the new record.

Source files
------------

// File: rtl/gtrg_pkg.sv
// Shared defaults and helpers for the GTRG trigger-record FIFO.
package gtrg_pkg;
   localparam int NCH_DEF        = 5;
   localparam int SCOPE_DEF      = 5;
   localparam int DEPTH_LOG2_DEF = 10;
   localparam int BXW_DEF        = 12;
   localparam int BX_MAX_LHC     = 3563;

   // One stored record: BX stamp above the per-channel scope windows.
   function automatic int rec_width(input int bxw, input int nch, input int scope);
      return bxw + nch * scope;
   endfunction
endpackage

// File: rtl/gtrg_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module gtrg_sdp_ram #(
   parameter int AW = 10,
   parameter int DW = 37
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   (* ram_style = "block" *) logic [DW-1:0] mem [2**AW];

   // Read-first: a same-address write and read returns the old word, which
   // the full-FIFO push+pop case relies on.
   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/gtrg_scope_fifo.sv
// Trigger-record FIFO: stores {BX stamp, per-channel DAV scope window} per push
// and replays records in order, with occupancy, warning and error bookkeeping.
module gtrg_scope_fifo
   import gtrg_pkg::*;
#(
   parameter int NCH        = NCH_DEF,
   parameter int SCOPE      = SCOPE_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int BXW        = BXW_DEF,
   parameter int AF_THR     = 1016
) (
   input  logic                  CLK,
   input  logic                  RDRST,
   input  logic                  PUSH,
   input  logic                  POP,
   input  logic                  BC0,
   input  logic [BXW-1:0]        BXMAX,
   input  logic [NCH-1:0]        DAV,
   input  logic [NCH-1:0]        KILL,
   input  logic                  CLRERR,
   output logic                  DOUT_VALID,
   output logic [NCH*SCOPE-1:0]  DOUT_DAV,
   output logic [BXW-1:0]        DOUT_BX,
   output logic                  EMPTY_B,
   output logic                  FULL,
   output logic                  AFULL,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  OVFL,
   output logic                  UNFL,
   output logic [7:0]            DROPCNT
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam int WW = NCH * SCOPE;
   localparam int RW = rec_width(BXW, NCH, SCOPE);
   localparam logic [CW-1:0] DEPTH_C = CW'(2**DEPTH_LOG2);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THR);

   logic [NCH-1:0]        dm;
   logic [SCOPE-2:0]      sh [NCH];
   logic [WW-1:0]         win;
   logic [BXW-1:0]        bx;
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [CW-1:0]         count;
   logic                  rd_ok, wr_ok, drop, unfl_ev;
   logic                  have_data;
   logic [RW-1:0]         ram_q;

   assign dm = DAV & ~KILL;

   always_comb begin
      win = '0;
      for (int c = 0; c < NCH; c++) win[c*SCOPE +: SCOPE] = {sh[c], dm[c]};
   end

   // The low SCOPE-1 bits of the window are exactly the next shift-register state.
   always_ff @(posedge CLK or posedge RDRST) begin
      if (RDRST) begin
         for (int c = 0; c < NCH; c++) sh[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) sh[c] <= win[c*SCOPE +: SCOPE-1];
      end
   end

   always_ff @(posedge CLK or posedge RDRST) begin
      if (RDRST)                  bx <= '0;
      else if (BC0 || bx == BXMAX) bx <= '0;
      else                        bx <= bx + 1'b1;
   end

   // PUSH/POP are single-cycle requests with no backpressure: a push is taken
   // unless the FIFO is full with no pop in the same cycle; a pop is taken when
   // the FIFO is non-empty and answered by DOUT_VALID one cycle later.
   assign rd_ok   = POP && (count != '0);
   assign wr_ok   = PUSH && ((count != DEPTH_C) || rd_ok);
   assign drop    = PUSH && !wr_ok;
   assign unfl_ev = POP && (count == '0);

   always_ff @(posedge CLK or posedge RDRST) begin
      if (RDRST) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Error events take precedence over a simultaneous clear.
   always_ff @(posedge CLK or posedge RDRST) begin
      if (RDRST) begin
         OVFL    <= 1'b0;
         UNFL    <= 1'b0;
         DROPCNT <= '0;
      end else begin
         if (drop)        OVFL <= 1'b1;
         else if (CLRERR) OVFL <= 1'b0;
         if (unfl_ev)     UNFL <= 1'b1;
         else if (CLRERR) UNFL <= 1'b0;
         if (CLRERR)                        DROPCNT <= drop ? 8'd1 : 8'd0;
         else if (drop && DROPCNT != 8'hFF) DROPCNT <= DROPCNT + 8'd1;
      end
   end

   always_ff @(posedge CLK or posedge RDRST) begin
      if (RDRST) begin
         DOUT_VALID <= 1'b0;
         have_data  <= 1'b0;
      end else begin
         DOUT_VALID <= rd_ok;
         have_data  <= have_data | rd_ok;
      end
   end

   gtrg_sdp_ram #(
      .AW (DEPTH_LOG2),
      .DW (RW)
   ) u_ram (
      .CLK   (CLK),
      .we    (wr_ok),
      .waddr (wptr),
      .wdata ({bx, win}),
      .re    (rd_ok),
      .raddr (rptr),
      .rdata (ram_q)
   );

   // The RAM output register only loads on a pop, so it already holds between
   // pops; have_data masks stale RAM contents until the first pop after reset.
   assign DOUT_DAV = have_data ? ram_q[WW-1:0]   : '0;
   assign DOUT_BX  = have_data ? ram_q[RW-1:WW]  : '0;
   assign EMPTY_B  = (count != '0);
   assign FULL     = (count == DEPTH_C);
   assign AFULL    = (count >= AF_C);
   assign COUNT    = count;

endmodule

// File: tb/tb_gtrg_scope_fifo.sv
// Directed plus randomized bench for gtrg_scope_fifo against a queue-based
// reference model of records, BX stamps and DAV history.
module tb_gtrg_scope_fifo;

   localparam int NCH   = 5;
   localparam int SCOPE = 5;
   localparam int DEPTH = 1024;
   localparam int BXW   = 12;
   localparam int AFT   = 1016;
   localparam int BXM   = 3563;
   localparam int WW    = NCH * SCOPE;
   localparam int RW    = BXW + WW;

   logic              CLK = 1'b0;
   logic              RDRST, PUSH, POP, BC0, CLRERR;
   logic [BXW-1:0]    BXMAX;
   logic [NCH-1:0]    DAV, KILL;
   logic              DOUT_VALID;
   logic [WW-1:0]     DOUT_DAV;
   logic [BXW-1:0]    DOUT_BX;
   logic              EMPTY_B, FULL, AFULL;
   logic [10:0]       COUNT;
   logic              OVFL, UNFL;
   logic [7:0]        DROPCNT;

   gtrg_scope_fifo dut (
      .CLK(CLK), .RDRST(RDRST), .PUSH(PUSH), .POP(POP), .BC0(BC0),
      .BXMAX(BXMAX), .DAV(DAV), .KILL(KILL), .CLRERR(CLRERR),
      .DOUT_VALID(DOUT_VALID), .DOUT_DAV(DOUT_DAV), .DOUT_BX(DOUT_BX),
      .EMPTY_B(EMPTY_B), .FULL(FULL), .AFULL(AFULL), .COUNT(COUNT),
      .OVFL(OVFL), .UNFL(UNFL), .DROPCNT(DROPCNT)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // scoreboard and reference model
   logic [RW-1:0]  exp_q[$];
   logic [RW-1:0]  exp_dout;
   bit             exp_valid, m_ovfl, m_unfl;
   int             m_drop;
   int             cyc, bx_ref;
   logic [NCH-1:0] hist [int];
   int             checks = 0;
   int             errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int n;
      n = exp_q.size();
      chk("count",   64'(COUNT), 64'(n));
      chk("empty_b", 64'(EMPTY_B), 64'(n != 0));
      chk("full",    64'(FULL), 64'(n == DEPTH));
      chk("afull",   64'(AFULL), 64'(n >= AFT));
      chk("valid",   64'(DOUT_VALID), 64'(exp_valid));
      chk("dout_dav", 64'(DOUT_DAV), 64'(exp_dout[WW-1:0]));
      chk("dout_bx", 64'(DOUT_BX), 64'(exp_dout[RW-1:WW]));
      chk("ovfl",    64'(OVFL), 64'(m_ovfl));
      chk("unfl",    64'(UNFL), 64'(m_unfl));
      chk("dropcnt", 64'(DROPCNT), 64'(m_drop));
   endtask

   // driver: one clock cycle of stimulus, model update, then output check
   task automatic cycle(input bit push, input bit pop, input bit bc0, input bit clr,
                        input logic [NCH-1:0] dav, input logic [NCH-1:0] kill);
      logic [WW-1:0]  w;
      logic [BXW-1:0] stamp;
      bit             rd, wr;
      int             idx;
      PUSH = push; POP = pop; BC0 = bc0; CLRERR = clr; DAV = dav; KILL = kill;
      hist[cyc] = dav & ~kill;
      w = '0;
      for (int c = 0; c < NCH; c++)
         for (int k = 0; k < SCOPE; k++) begin
            idx = cyc - k;
            if (hist.exists(idx)) w[c*SCOPE + k] = hist[idx][c];
         end
      stamp = BXW'((cyc - bx_ref) % (BXM + 1));
      rd = pop && (exp_q.size() != 0);
      wr = push && (exp_q.size() < DEPTH || rd);
      exp_valid = rd;
      if (rd) exp_dout = exp_q.pop_front();
      if (wr) exp_q.push_back({stamp, w});
      if (clr) begin m_ovfl = 0; m_unfl = 0; m_drop = 0; end
      if (push && !wr) begin m_ovfl = 1; if (m_drop < 255) m_drop++; end
      if (pop && !rd) m_unfl = 1;
      if (bc0) bx_ref = cyc + 1;
      @(posedge CLK);
      cyc++;
      if (hist.exists(cyc - SCOPE)) hist.delete(cyc - SCOPE);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0);
   endtask

   task automatic do_reset();
      RDRST = 1'b1;
      PUSH = 0; POP = 0; BC0 = 0; CLRERR = 0; DAV = '0; KILL = '0;
      #1;
      exp_q.delete();
      exp_dout = '0; exp_valid = 0; m_ovfl = 0; m_unfl = 0; m_drop = 0;
      chk("rst_count", 64'(COUNT), 64'd0);
      chk("rst_empty_b", 64'(EMPTY_B), 64'd0);
      chk("rst_valid", 64'(DOUT_VALID), 64'd0);
      check_all();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RDRST = 1'b0;
      cyc = 0; bx_ref = 0;
      hist.delete();
   endtask

   initial begin
      RDRST = 1'b0; PUSH = 0; POP = 0; BC0 = 0; CLRERR = 0; DAV = '0; KILL = '0;
      BXMAX = BXW'(BXM);
      cyc = 0; bx_ref = 0;
      #2;
      do_reset();

      // single DAV pulse two cycles before a push lands in window bit 2
      cycle(0, 0, 0, 0, 5'b00100, '0);
      idle(1);
      cycle(1, 0, 0, 0, '0, '0);
      cycle(0, 1, 0, 0, '0, '0);
      chk("t1_valid", 64'(DOUT_VALID), 64'd1);
      chk("t1_dav", 64'(DOUT_DAV), 64'h1000);
      idle(1);

      // same pattern with channel 2 killed
      cycle(0, 0, 0, 0, 5'b00100, 5'b00100);
      cycle(0, 0, 0, 0, '0, 5'b00100);
      cycle(1, 0, 0, 0, '0, 5'b00100);
      cycle(0, 1, 0, 0, '0, 5'b00100);
      chk("kill_dav", 64'(DOUT_DAV), 64'd0);

      // BC0 restarts the stamp
      cycle(0, 0, 1, 0, '0, '0);
      idle(10);
      cycle(1, 0, 0, 0, '0, '0);
      cycle(0, 1, 0, 0, '0, '0);
      chk("bc0_bx", 64'(DOUT_BX), 64'd10);

      // BX wrap at BXMAX
      cycle(0, 0, 1, 0, '0, '0);
      idle(BXM - 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0, '0);
      cycle(0, 1, 0, 0, '0, '0);
      chk("wrap_bx0", 64'(DOUT_BX), 64'd3562);
      cycle(0, 1, 0, 0, '0, '0);
      chk("wrap_bx1", 64'(DOUT_BX), 64'd3563);
      cycle(0, 1, 0, 0, '0, '0);
      chk("wrap_bx2", 64'(DOUT_BX), 64'd0);

      // fill to full, overflow, simultaneous push+pop at full, drain
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 0, 0, 0, NCH'($urandom), '0);
         if (i == AFT - 2) chk("afull_lo", 64'(AFULL), 64'd0);
         if (i == AFT - 1) chk("afull_hi", 64'(AFULL), 64'd1);
      end
      chk("full_flag", 64'(FULL), 64'd1);
      chk("full_count", 64'(COUNT), 64'd1024);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, NCH'($urandom), '0);
      chk("ovfl_set", 64'(OVFL), 64'd1);
      chk("drop3", 64'(DROPCNT), 64'd3);
      cycle(1, 1, 0, 0, NCH'($urandom), '0);
      chk("pp_full_count", 64'(COUNT), 64'd1024);
      chk("pp_full_drop", 64'(DROPCNT), 64'd3);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, '0, '0);
      cycle(0, 1, 0, 0, '0, '0);
      chk("unfl_set", 64'(UNFL), 64'd1);
      cycle(0, 0, 0, 1, '0, '0);
      chk("clr_ovfl", 64'(OVFL), 64'd0);
      chk("clr_drop", 64'(DROPCNT), 64'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
               bit'($urandom_range(0, 99) == 0), bit'($urandom_range(0, 49) == 0),
               NCH'($urandom), NCH'($urandom_range(0, 3) == 0 ? $urandom : 0));

      // reset with five records held, right after a pop
      while (exp_q.size() != 0) cycle(0, 1, 0, 0, '0, '0);
      for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, NCH'($urandom), '0);
      cycle(0, 1, 0, 0, '0, '0);
      chk("pre_rst_count", 64'(COUNT), 64'd5);
      do_reset();
      cycle(1, 0, 0, 0, 5'b10101, '0);
      cycle(0, 1, 0, 0, '0, '0);
      chk("post_rst_valid", 64'(DOUT_VALID), 64'd1);
      chk("post_rst_dav", 64'(DOUT_DAV), 64'h0100401);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
